// File: rtl/stream_prefetch_buffer_pkg.sv
// Shared types and defaults for the stream prefetch buffer.
// The optional SB_STATS_EN build uses sat_inc16 for its lookup counters.
package lc3b_types;

   localparam int SB_DEPTH  = 4;
   localparam int SB_LINE_W = 128;

   typedef enum logic [1:0] {
      SB_IDLE  = 2'd0,
      SB_FETCH = 2'd1,
      SB_WAIT  = 2'd2,
      SB_DRAIN = 2'd3
   } sb_state_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/stream_prefetch_buffer_fifo.sv
// Entry FIFO for the stream buffer: {adr, line} storage, head/tail pointers and count,
// plus an address probe across all valid entries for store invalidation.
module sb_fifo #(
   parameter int ADR_W  = 12,
   parameter int DATA_W = 128,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic [ADR_W-1:0]         push_adr,
   input  logic [DATA_W-1:0]        push_data,
   input  logic                     pop,
   output logic [ADR_W-1:0]         head_adr,
   output logic [DATA_W-1:0]        head_data,
   output logic [$clog2(DEPTH):0]   count,
   input  logic [ADR_W-1:0]         cmp_adr,
   output logic                     cmp_hit
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [ADR_W-1:0]  adr_mem_r  [DEPTH];
   logic [DATA_W-1:0] data_mem_r [DEPTH];
   logic [PTR_W-1:0]  head_r, tail_r, off_s;
   logic [CNT_W-1:0]  count_r;
   logic [DEPTH-1:0]  match_s;
   logic              push_ok_s, pop_ok_s;

   assign push_ok_s = push & (count_r != DEPTH_C);
   assign pop_ok_s  = pop & (count_r != {CNT_W{1'b0}});

   // Entry storage; contents are deliberately left unreset.
   always_ff @(posedge clk) begin
      if (push_ok_s) begin
         adr_mem_r[tail_r]  <= push_adr;
         data_mem_r[tail_r] <= push_data;
      end
   end

   // Pointers and occupancy; flush overrides any push/pop in the same cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_r  <= {PTR_W{1'b0}};
         tail_r  <= {PTR_W{1'b0}};
         count_r <= {CNT_W{1'b0}};
      end else if (flush) begin
         head_r  <= {PTR_W{1'b0}};
         tail_r  <= {PTR_W{1'b0}};
         count_r <= {CNT_W{1'b0}};
      end else begin
         if (push_ok_s) tail_r <= tail_r + PTR_W'(1'b1);
         if (pop_ok_s)  head_r <= head_r + PTR_W'(1'b1);
         count_r <= count_r + {{PTR_W{1'b0}}, push_ok_s} - {{PTR_W{1'b0}}, pop_ok_s};
      end
   end

   // An entry is valid when its distance from head is below the count.
   always_comb begin
      off_s   = {PTR_W{1'b0}};
      match_s = {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         off_s      = PTR_W'(i) - head_r;
         match_s[i] = ({1'b0, off_s} < count_r) && (adr_mem_r[i] == cmp_adr);
      end
   end

   assign cmp_hit   = |match_s;
   assign head_adr  = adr_mem_r[head_r];
   assign head_data = data_mem_r[head_r];
   assign count     = count_r;

endmodule

// File: rtl/stream_prefetch_buffer.sv
// Sequential-line stream prefetch buffer: probes the head on cache misses and keeps
// fetching ahead. Define SB_STATS_EN to add saturating hit_cnt / miss_cnt outputs.
module stream_prefetch_buffer
   import lc3b_types::*;
#(
   parameter int ADDR_W = 12,
   parameter int LINE_W = SB_LINE_W,
   parameter int DEPTH  = SB_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              lookup,
   input  logic [ADDR_W-1:0] lookup_adr,
   output logic              sb_hit,
   output logic [LINE_W-1:0] sb_rdata,
   input  logic              inv,
   input  logic [ADDR_W-1:0] inv_adr,
   output logic              pf_read,
   output logic [ADDR_W-1:0] pf_adr,
   input  logic              pf_resp,
   input  logic [LINE_W-1:0] pf_rdata,
   output logic              busy
`ifdef SB_STATS_EN
   ,
   output logic [15:0]       hit_cnt,
   output logic [15:0]       miss_cnt
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
   localparam logic [ADDR_W-1:0] ADR_ONE = ADDR_W'(1'b1);

   sb_state_t         state_r, state_nxt_s;
   logic [ADDR_W-1:0] next_adr_r, next_adr_nxt_s;
   logic [ADDR_W-1:0] pf_adr_r, pf_adr_nxt_s;
   logic              pf_read_r, pf_read_nxt_s;
   logic              busy_r, busy_nxt_s;
   logic [CNT_W-1:0]  count_s, count_after_s;
   logic [ADDR_W-1:0] head_adr_s, flush_adr_s;
   logic [LINE_W-1:0] head_data_s;
   logic              hit_s, miss_s, inv_entry_hit_s, inv_hit_s, flush_s;
   logic              resp_s, push_s, pop_s;

   sb_fifo #(
      .ADR_W  (ADDR_W),
      .DATA_W (LINE_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush_s),
      .push      (push_s),
      .push_adr  (pf_adr_r),
      .push_data (pf_rdata),
      .pop       (pop_s),
      .head_adr  (head_adr_s),
      .head_data (head_data_s),
      .count     (count_s),
      .cmp_adr   (inv_adr),
      .cmp_hit   (inv_entry_hit_s)
   );

   // Probe decode; a lookup miss outranks invalidation when choosing the restart address.
   always_comb begin
      hit_s         = lookup & (count_s != {CNT_W{1'b0}}) & (head_adr_s == lookup_adr);
      miss_s        = lookup & ~hit_s;
      inv_hit_s     = inv & (inv_entry_hit_s | (pf_read_r & (pf_adr_r == inv_adr)));
      flush_s       = miss_s | inv_hit_s;
      flush_adr_s   = miss_s ? lookup_adr : inv_adr;
      resp_s        = pf_resp & ((state_r == SB_FETCH) | (state_r == SB_WAIT));
      pop_s         = hit_s & ~flush_s;
      push_s        = resp_s & ~flush_s & (count_s != DEPTH_C);
      count_after_s = count_s + {{PTR_W{1'b0}}, push_s} - {{PTR_W{1'b0}}, pop_s};
   end

   // State, stream address and registered request outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= SB_IDLE;
         next_adr_r <= {ADDR_W{1'b0}};
         pf_adr_r   <= {ADDR_W{1'b0}};
         pf_read_r  <= 1'b0;
         busy_r     <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         next_adr_r <= next_adr_nxt_s;
         pf_adr_r   <= pf_adr_nxt_s;
         pf_read_r  <= pf_read_nxt_s;
         busy_r     <= busy_nxt_s;
      end
   end

   // Next state; a flush with a request in flight must drain the stale response.
   always_comb begin
      state_nxt_s    = state_r;
      next_adr_nxt_s = next_adr_r;
      case (state_r)
         SB_IDLE: begin
            if (flush_s) begin
               state_nxt_s    = SB_FETCH;
               next_adr_nxt_s = flush_adr_s + ADR_ONE;
            end else if (pop_s) begin
               state_nxt_s = SB_FETCH;
            end else begin
               state_nxt_s = SB_IDLE;
            end
         end
         SB_FETCH, SB_WAIT: begin
            if (flush_s) begin
               next_adr_nxt_s = flush_adr_s + ADR_ONE;
               state_nxt_s    = pf_resp ? SB_FETCH : SB_DRAIN;
            end else if (resp_s) begin
               next_adr_nxt_s = next_adr_r + ADR_ONE;
               state_nxt_s    = (count_after_s < DEPTH_C) ? SB_FETCH : SB_IDLE;
            end else begin
               state_nxt_s = SB_WAIT;
            end
         end
         SB_DRAIN: begin
            next_adr_nxt_s = flush_s ? (flush_adr_s + ADR_ONE) : next_adr_r;
            state_nxt_s    = pf_resp ? SB_FETCH : SB_DRAIN;
         end
         default: begin
            state_nxt_s = SB_IDLE;
         end
      endcase
   end

   // Output decode of the next state; WAIT and DRAIN hold the issued address.
   always_comb begin
      pf_read_nxt_s = (state_nxt_s == SB_FETCH) | (state_nxt_s == SB_WAIT) |
                      (state_nxt_s == SB_DRAIN);
      busy_nxt_s    = pf_read_nxt_s;
      case (state_nxt_s)
         SB_FETCH: pf_adr_nxt_s = next_adr_nxt_s;
         SB_IDLE:  pf_adr_nxt_s = {ADDR_W{1'b0}};
         default:  pf_adr_nxt_s = pf_adr_r;
      endcase
   end

   assign sb_hit   = hit_s;
   assign sb_rdata = head_data_s;
   assign pf_read  = pf_read_r;
   assign pf_adr   = pf_adr_r;
   assign busy     = busy_r;

`ifdef SB_STATS_EN
   logic [15:0] hit_cnt_r, miss_cnt_r;

   // Saturating lookup statistics.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hit_cnt_r  <= 16'd0;
         miss_cnt_r <= 16'd0;
      end else begin
         if (hit_s)  hit_cnt_r  <= sat_inc16(hit_cnt_r);
         if (miss_s) miss_cnt_r <= sat_inc16(miss_cnt_r);
      end
   end

   assign hit_cnt  = hit_cnt_r;
   assign miss_cnt = miss_cnt_r;
`endif

endmodule

// File: doc/stream_prefetch_buffer.md
STREAM_PREFETCH_BUFFER -- requirements
Module: stream_prefetch_buffer

Interface
REQ-001 Parameters (name, default, meaning):
- ADDR_W, 12, line-address width
- LINE_W, 128, line width in bits
- DEPTH, 4, buffer entries; power of two, at least 2
REQ-002 Ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-003 Ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Ports: lookup  in  1  cache miss probe strobe.
REQ-005 Ports: lookup_adr  in  ADDR_W  missing line address.
REQ-006 Ports: sb_hit  out  1  head entry matches lookup_adr; combinational.
REQ-007 Ports: sb_rdata  out  LINE_W  head entry data.
REQ-008 Ports: inv  in  1  store-invalidate strobe.
REQ-009 Ports: inv_adr  in  ADDR_W  line written by the cache.
REQ-010 Ports: pf_read  out  1  memory read request.
REQ-011 Ports: pf_adr  out  ADDR_W  request line address.
REQ-012 Ports: pf_resp  in  1  one-cycle memory response.
REQ-013 Ports: pf_rdata  in  LINE_W  response data.
REQ-014 Ports: busy  out  1  request outstanding.

Function
REQ-015 The buffer SHALL be a FIFO of DEPTH entries; each entry holds {adr, line}, with head/tail pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits.
REQ-016 sb_hit SHALL be (lookup && count!=0 && head.adr==lookup_adr), evaluated in the same cycle with zero latency.
REQ-017 A hit SHALL pop the head at the clock edge; the stream continues unchanged.
REQ-018 A lookup miss SHALL flush all entries and set next_adr = lookup_adr+1, modulo 2^ADDR_W, so addresses wrap.
REQ-019 FSM states:
- IDLE: no stream.
- FETCH: pf_read=1, pf_adr=next_adr.
- WAIT: request held with pf_read and pf_adr stable until pf_resp.
- DRAIN: in-flight response is stale and will be discarded.
REQ-020 Transitions:
- IDLE->FETCH on a lookup miss.
- FETCH->WAIT when pf_resp=0.
- FETCH or WAIT, on pf_resp: push {pf_adr, pf_rdata}, next_adr+=1, then go to FETCH if count_after<DEPTH, else IDLE-full.
- IDLE-full->FETCH when a pop frees an entry.
REQ-021 pf_read SHALL never be deasserted, and pf_adr never changed, before pf_resp.
REQ-022 Flush during FETCH/WAIT SHALL go to DRAIN; on pf_resp the data is discarded and the FSM enters FETCH at the new next_adr.
REQ-023 A push and a pop in the same cycle SHALL leave count unchanged.
REQ-024 Push SHALL be suppressed when count==DEPTH; the FSM never requests while full.
REQ-025 If inv_adr matches any valid entry, or the outstanding pf_adr, the stream SHALL be flushed with next_adr = inv_adr+1; the DRAIN rule applies.
REQ-026 When lookup miss and inv occur in the same cycle, the lookup SHALL take priority.
REQ-027 busy = (state is FETCH, WAIT or DRAIN).

Reset
REQ-028 While rst_n=0: count=0, pointers=0, state=IDLE, next_adr=0; pf_read=0, pf_adr=0, sb_hit=0, busy=0.
REQ-029 Reset SHALL apply immediately, even mid-request; a pf_resp arriving after reset is ignored in IDLE.
REQ-030 Entry data SHALL not be reset.

Configuration
REQ-031 Macro SB_STATS_EN defined: adds outputs hit_cnt and miss_cnt, 16 bits each, saturating, incremented on lookup hit or miss, and cleared by rst_n.
REQ-032 Macro SB_STATS_EN undefined: the counters and their ports are absent; all other behaviour is identical.

Structure
REQ-033 The shared package (lc3b_types) SHALL hold the FSM state enum sb_state_t and the default constants SB_DEPTH and SB_LINE_W.
REQ-034 The FIFO storage and pointers SHALL be one sub-module, sb_fifo, parametrised by width and depth; the FSM and compare logic stay in the top module.

Verification
REQ-035 Lookup 0x010 on an empty buffer -> miss; pf_read with pf_adr=0x011, 0x012, 0x013, 0x014; then idle when full, count=4.
REQ-036 After REQ-035, lookup 0x011 -> sb_hit=1 with line of 0x011; next cycle pf_adr=0x015.
REQ-037 Lookup 0x050 while the 0x012 request is in WAIT -> DRAIN; 0x012 data is discarded; next request is pf_adr=0x051; count=0 before that push.
REQ-038 Lookup 0xFFF miss -> first pf_adr=0x000 (wrap).
REQ-039 inv_adr=0x013 with entries 0x011..0x014 -> flush; next pf_adr=0x014.
REQ-040 rst_n low during WAIT -> pf_read=0 asynchronously; a later pf_resp leaves count=0.
